// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Round-robin arbiter that merges I-cache line fills and D-cache
//               fills/write-backs onto one shared memory port. It allows only
//               one memory transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache side
  input  logic                  inst_read,
  input  logic [ADDR_WIDTH-1:0] inst_address,
  output logic [LINE_WIDTH-1:0] inst_rdata,
  output logic                  inst_resp,
  // D-cache side
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [LINE_WIDTH-1:0] data_wdata,
  output logic [LINE_WIDTH-1:0] data_rdata,
  output logic                  data_resp,
  // Shared memory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic                  d_req;
  logic                  pick_d;

  // A combined read+write from the D-cache counts as a single write request.
  assign d_req  = data_read | data_write;
  // D wins when it is alone, or on a tie when I was granted last.
  assign pick_d = d_req & (~inst_read | (last_grant_q == GRANT_I));

  // Memory-side address/data come only from the latched copy, so requester
  // changes during a transaction cannot leak onto the bus.
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  // Read data is routed to both sides; only the pulsed side consumes it.
  assign inst_rdata  = mem_rdata;
  assign data_rdata  = mem_rdata;

  // State and transaction registers; reset abandons any open transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // Arbitration, request latching, memory strobes and completion pulses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    inst_resp    = 1'b0;
    data_resp    = 1'b0;

    case (state_q)
      IDLE: begin
        // Strobes stay low here, which guarantees a gap cycle between
        // consecutive memory transactions. mem_resp is ignored in IDLE.
        if (pick_d) begin
          state_d = SERVE_D;
          addr_d  = data_address;
          wdata_d = data_wdata;
          write_d = data_write;
        end else if (inst_read) begin
          state_d = SERVE_I;
          addr_d  = inst_address;
          wdata_d = data_wdata;
          write_d = 1'b0;
        end
      end

      SERVE_I: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          inst_resp    = 1'b1;
          state_d      = IDLE;
          last_grant_d = GRANT_I;
        end
      end

      SERVE_D: begin
        mem_read  = ~write_q;
        mem_write = write_q;
        if (mem_resp) begin
          data_resp    = 1'b1;
          state_d      = IDLE;
          last_grant_d = GRANT_D;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Directed self-checking bench for cache_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          inst_read;
  logic [AW-1:0] inst_address;
  logic [LW-1:0] inst_rdata;
  logic          inst_resp;
  logic          data_read;
  logic          data_write;
  logic [AW-1:0] data_address;
  logic [LW-1:0] data_wdata;
  logic [LW-1:0] data_rdata;
  logic          data_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int total = 0;
  int bad   = 0;

  localparam logic [LW-1:0] RD_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] RD_3C = {32{8'h3C}};
  localparam logic [LW-1:0] W1    = {8{32'hDEADBEEF}};
  localparam logic [LW-1:0] W2    = {8{32'h12345678}};

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_read    (inst_read),
    .inst_address (inst_address),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_address (data_address),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_resp    (data_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge; inputs are driven there and
  // outputs are checked a further 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    inst_read    = 1'b0;
    inst_address = '0;
    data_read    = 1'b0;
    data_write   = 1'b0;
    data_address = '0;
    data_wdata   = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    #2;
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    total++; if ({inst_resp, data_resp} !== 2'b00) begin bad++; $display("FAIL reset_resp: got %b want 00", {inst_resp, data_resp}); end
    total++; if (mem_address !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_address); end
    total++; if (mem_wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_i();
    inst_read    = 1'b1;
    inst_address = 32'h60;
    #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL si_idle_read: got %b want 0", mem_read); end
    cyc();  // SERVE_I, cycle 1
    #1;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL si_read_c1: got %b want 1", mem_read); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL si_write_c1: got %b want 0", mem_write); end
    total++; if (mem_address !== 32'h60) begin bad++; $display("FAIL si_addr: got %h want 60", mem_address); end
    for (int k = 2; k <= 3; k++) begin
      cyc();
      #1;
      total++; if ({mem_read, inst_resp} !== 2'b10) begin bad++; $display("FAIL si_hold_c%0d: got %b want 10", k, {mem_read, inst_resp}); end
    end
    cyc();  // cycle 4: memory answers
    mem_resp  = 1'b1;
    mem_rdata = RD_A5;
    inst_read = 1'b0;
    #1;
    total++; if (inst_resp !== 1'b1) begin bad++; $display("FAIL si_resp: got %b want 1", inst_resp); end
    total++; if (inst_rdata !== RD_A5) begin bad++; $display("FAIL si_rdata: got %h want %h", inst_rdata, RD_A5); end
    total++; if (data_resp !== 1'b0) begin bad++; $display("FAIL si_dresp: got %b want 0", data_resp); end
    cyc();
    mem_resp = 1'b0;
    #1;
    total++; if ({inst_resp, mem_read} !== 2'b00) begin bad++; $display("FAIL si_after: got %b want 00", {inst_resp, mem_read}); end
  endtask

  task automatic test_tie();
    apply_reset();
    inst_read    = 1'b1;
    inst_address = 32'h100;
    data_read    = 1'b1;
    data_address = 32'h200;
    cyc();  // SERVE_D expected (last_grant=I after reset)
    #1;
    total++; if (mem_address !== 32'h200) begin bad++; $display("FAIL tie_first_addr: got %h want 200", mem_address); end
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL tie_first_read: got %b want 1", mem_read); end
    cyc();
    mem_resp  = 1'b1;
    mem_rdata = RD_3C;
    data_read = 1'b0;
    #1;
    total++; if ({data_resp, inst_resp} !== 2'b10) begin bad++; $display("FAIL tie_dresp: got %b want 10", {data_resp, inst_resp}); end
    total++; if (data_rdata !== RD_3C) begin bad++; $display("FAIL tie_drdata: got %h want %h", data_rdata, RD_3C); end
    cyc();  // the single idle cycle
    mem_resp = 1'b0;
    #1;
    total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL tie_gap: got %b want 00", {mem_read, mem_write}); end
    cyc();  // SERVE_I
    #1;
    total++; if ({mem_read, mem_address} !== {1'b1, 32'h100}) begin bad++; $display("FAIL tie_second: got %b/%h want 1/100", mem_read, mem_address); end
    mem_resp  = 1'b1;
    inst_read = 1'b0;
    #1;
    total++; if ({inst_resp, data_resp} !== 2'b10) begin bad++; $display("FAIL tie_iresp: got %b want 10", {inst_resp, data_resp}); end
    cyc();
    mem_resp = 1'b0;
  endtask

  task automatic test_round_robin();
    logic        exp_d;
    logic [AW-1:0] exp_a;
    apply_reset();
    inst_read    = 1'b1;
    inst_address = 32'h400;
    data_write   = 1'b1;
    data_address = 32'h300;
    data_wdata   = W1;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2 == 0);
      exp_a = exp_d ? 32'h300 : 32'h400;
      cyc();  // SERVE_x
      #1;
      total++; if ({mem_write, mem_read} !== {exp_d, ~exp_d}) begin bad++; $display("FAIL rr_op_t%0d: got w/r=%b want %b", t, {mem_write, mem_read}, {exp_d, ~exp_d}); end
      total++; if (mem_address !== exp_a) begin bad++; $display("FAIL rr_addr_t%0d: got %h want %h", t, mem_address, exp_a); end
      mem_resp = 1'b1;
      #1;
      total++; if ({data_resp, inst_resp} !== {exp_d, ~exp_d}) begin bad++; $display("FAIL rr_resp_t%0d: got d/i=%b want %b", t, {data_resp, inst_resp}, {exp_d, ~exp_d}); end
      cyc();  // idle gap
      mem_resp = 1'b0;
      #1;
      total++; if ({mem_read, mem_write} !== 2'b00) begin bad++; $display("FAIL rr_gap_t%0d: got %b want 00", t, {mem_read, mem_write}); end
    end
    inst_read  = 1'b0;
    data_write = 1'b0;
    cyc();
  endtask

  task automatic test_latch();
    data_write   = 1'b1;
    data_address = 32'h500;
    data_wdata   = W1;
    cyc();  // SERVE_D
    #1;
    total++; if ({mem_address, mem_wdata} !== {32'h500, W1}) begin bad++; $display("FAIL latch_start: got %h/%h want 500/%h", mem_address, mem_wdata, W1); end
    data_address = 32'h5C0;
    data_wdata   = W2;
    data_write   = 1'b0;
    cyc();
    #1;
    total++; if ({mem_write, mem_address} !== {1'b1, 32'h500}) begin bad++; $display("FAIL latch_addr: got %b/%h want 1/500", mem_write, mem_address); end
    total++; if (mem_wdata !== W1) begin bad++; $display("FAIL latch_wdata: got %h want %h", mem_wdata, W1); end
    cyc();
    mem_resp = 1'b1;
    #1;
    total++; if ({data_resp, mem_address, mem_wdata} !== {1'b1, 32'h500, W1}) begin bad++; $display("FAIL latch_resp: got %b/%h want 1/500", data_resp, mem_address); end
    cyc();
    mem_resp = 1'b0;
    #1;
    total++; if ({data_resp, mem_write} !== 2'b00) begin bad++; $display("FAIL latch_after: got %b want 00", {data_resp, mem_write}); end
  endtask

  task automatic test_reset_mid();
    inst_read    = 1'b1;
    inst_address = 32'h700;
    cyc();  // SERVE_I cycle 1
    #1;
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rm_read: got %b want 1", mem_read); end
    cyc();  // SERVE_I cycle 2: reset hits
    rst       = 1'b1;
    inst_read = 1'b0;
    #1;
    total++; if ({mem_read, mem_write, inst_resp} !== 3'b000) begin bad++; $display("FAIL rm_outputs: got %b want 000", {mem_read, mem_write, inst_resp}); end
    total++; if (mem_address !== '0) begin bad++; $display("FAIL rm_addr: got %h want 0", mem_address); end
    cyc();
    rst       = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = RD_A5;
    #1;
    total++; if ({inst_resp, data_resp} !== 2'b00) begin bad++; $display("FAIL rm_stray_resp: got %b want 00", {inst_resp, data_resp}); end
    cyc();
    mem_resp = 1'b0;
    #1;
    total++; if ({mem_read, mem_write, inst_resp} !== 3'b000) begin bad++; $display("FAIL rm_stay_idle: got %b want 000", {mem_read, mem_write, inst_resp}); end
  endtask

  task automatic test_rw_both();
    data_read    = 1'b1;
    data_write   = 1'b1;
    data_address = 32'h40;
    data_wdata   = W2;
    cyc();  // SERVE_D
    #1;
    total++; if ({mem_write, mem_read} !== 2'b10) begin bad++; $display("FAIL rw_op: got w/r=%b want 10", {mem_write, mem_read}); end
    total++; if (mem_address !== 32'h40) begin bad++; $display("FAIL rw_addr: got %h want 40", mem_address); end
    mem_resp   = 1'b1;
    data_read  = 1'b0;
    data_write = 1'b0;
    #1;
    total++; if ({data_resp, inst_resp} !== 2'b10) begin bad++; $display("FAIL rw_resp: got %b want 10", {data_resp, inst_resp}); end
    cyc();
    mem_resp = 1'b0;
    #1;
    total++; if ({data_resp, mem_write, mem_read} !== 3'b000) begin bad++; $display("FAIL rw_after: got %b want 000", {data_resp, mem_write, mem_read}); end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_tie();
    test_round_robin();
    test_latch();
    test_reset_mid();
    test_rw_both();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
